// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with req/ack data-memory port
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fault
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;

  logic            accept, is_mem, fault, start, done;
  logic [RD_W-1:0] lat_rd;
  logic            lat_reg_write;
  logic            lat_is_load;

  assign accept = ex_valid && ex_ready;
  assign is_mem = ex_is_load || ex_is_store;
  assign fault  = is_mem && ((ex_alu_result[1:0] != 2'b00) || (ex_is_load && ex_is_store));
  assign start  = accept && is_mem && !fault;
  assign done   = (state == ACCESS) && dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (dmem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ex_ready = (state == IDLE);
  end

  // A write to x0 is never reported as a register write, on any retirement path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      lat_is_load   <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_data       <= '0;
      wb_fault      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid     <= 1'b1;
        wb_rd        <= ex_rd;
        wb_reg_write <= ex_reg_write && (ex_rd != '0);
        wb_data      <= ex_alu_result;
        wb_fault     <= 1'b0;
      end else if (accept && fault) begin
        wb_valid     <= 1'b1;
        wb_rd        <= ex_rd;
        wb_reg_write <= 1'b0;
        wb_data      <= ex_alu_result;
        wb_fault     <= 1'b1;
      end else if (start) begin
        dmem_req      <= 1'b1;
        dmem_we       <= ex_is_store;
        dmem_addr     <= ex_alu_result;
        dmem_wdata    <= ex_store_data;
        lat_rd        <= ex_rd;
        lat_reg_write <= ex_reg_write;
        lat_is_load   <= ex_is_load;
      end
      if (done) begin
        dmem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_fault <= 1'b0;
        wb_rd    <= lat_rd;
        if (lat_is_load) begin
          wb_data      <= dmem_rdata;
          wb_reg_write <= lat_reg_write && (lat_rd != '0);
        end else begin
          wb_data      <= dmem_addr;
          wb_reg_write <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        wb_fault;

  mem_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        fault;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] data, input logic fault);
    wb_exp_t e;
    e.rd = rd; e.rw = rw; e.data = data; e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic ld,
                       input logic st, input logic [4:0] rd, input logic rw);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd;
    ex_is_load = ld; ex_is_store = st; ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got pulse rd=%0d data=0x%08h, expected none", wb_rd, wb_data);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        if (wb_reg_write !== e.rw || wb_data !== e.data || wb_fault !== e.fault ||
            (!e.fault && wb_rd !== e.rd)) begin
          miscompares++;
          $display("FAIL wb_bundle: got rd=%0d rw=%0b data=0x%08h fault=%0b, expected rd=%0d rw=%0b data=0x%08h fault=%0b",
                   wb_rd, wb_reg_write, wb_data, wb_fault, e.rd, e.rw, e.data, e.fault);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back ALU results
    drive(32'h11, 32'h0, 1'b0, 1'b0, 5'd3, 1'b1); push(5'd3, 1'b1, 32'h11, 1'b0);
    step();
    chk("b2b_ready1", {31'b0, ex_ready}, 32'd1);
    drive(32'h22, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1); push(5'd4, 1'b1, 32'h22, 1'b0);
    step();
    chk("b2b_ready2", {31'b0, ex_ready}, 32'd1);
    drive(32'h33, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1); push(5'd5, 1'b1, 32'h33, 1'b0);
    step();
    chk("b2b_ready3", {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b0;

    // LOAD with ack sampled on the third edge after the request
    drive(32'h100, 32'h0, 1'b1, 1'b0, 5'd7, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(32'h55, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1);
      chk("ld_req", {31'b0, dmem_req}, 32'd1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", {31'b0, dmem_we}, 32'd0);
      chk("ld_ready", {31'b0, ex_ready}, 32'd0);
      if (i == 2) begin
        ex_valid = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        push(5'd7, 1'b1, 32'hDEADBEEF, 1'b0);
      end
      step();
    end
    dmem_ack = 1'b0;
    chk("ld_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("ld_ready_back", {31'b0, ex_ready}, 32'd1);

    // STORE acked on its first cycle
    drive(32'h40, 32'hCAFEF00D, 1'b0, 1'b1, 5'd9, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("st_req", {31'b0, dmem_req}, 32'd1);
    chk("st_we", {31'b0, dmem_we}, 32'd1);
    chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
    chk("st_addr", dmem_addr, 32'h40);
    dmem_ack = 1'b1;
    push(5'd9, 1'b0, 32'h40, 1'b0);
    step();
    dmem_ack = 1'b0;
    chk("st_req_drop", {31'b0, dmem_req}, 32'd0);

    // Misaligned load, then both memory flags set
    drive(32'h102, 32'h0, 1'b1, 1'b0, 5'd6, 1'b1); push(5'd6, 1'b0, 32'h102, 1'b1);
    step();
    chk("mis_no_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_ready", {31'b0, ex_ready}, 32'd1);
    drive(32'h100, 32'h0, 1'b1, 1'b1, 5'd8, 1'b1); push(5'd8, 1'b0, 32'h100, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("ill_no_req", {31'b0, dmem_req}, 32'd0);

    // LOAD to x0
    drive(32'h200, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    step();
    ex_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h5;
    push(5'd0, 1'b0, 32'h5, 1'b0);
    step();
    dmem_ack = 1'b0;

    // Reset during an outstanding LOAD, then a late ack
    drive(32'h300, 32'h0, 1'b1, 1'b0, 5'd10, 1'b1);
    step();
    ex_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_mid_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_mid_ready", {31'b0, ex_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h77;
    step();
    dmem_ack = 1'b0;
    chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("late_ack_ready", {31'b0, ex_ready}, 32'd1);
    repeat (3) step();

    chk("pending_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, sitting directly downstream of the execute-stage ALU. It captures the ALU result and control for one instruction. For LOAD/STORE it uses the ALU result as a word address and runs a req/ack transaction on the data-memory port, stalling execute until the transaction completes. It then presents a registered MEM/WB bundle to write-back; non-memory instructions pass through in one cycle.

## Interface
- `DATA_W`, 32, datapath and address width
- `RD_W`, 5, destination-register index width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  execute presents an instruction
- `ex_ready`  out  1  stage can accept; transfer occurs on an edge where `ex_valid && ex_ready`
- `ex_alu_result`  in  DATA_W  ALU output (address for LOAD/STORE, result otherwise)
- `ex_store_data`  in  DATA_W  register value to store
- `ex_is_load`, `ex_is_store`  in  1 each  memory-op decode
- `ex_rd`  in  RD_W  destination register
- `ex_reg_write`  in  1  instruction writes `ex_rd`
- `dmem_req`  out  1  memory request, held until acknowledged
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  DATA_W  byte address, word aligned
- `dmem_wdata`  out  DATA_W  store data
- `dmem_ack`  in  1  request completes on this edge
- `dmem_rdata`  in  DATA_W  load data, valid when `dmem_ack`=1
- `wb_valid`  out  1  one-cycle pulse per retired instruction
- `wb_rd`  out  RD_W  write-back register
- `wb_reg_write`  out  1  write-back enable
- `wb_data`  out  DATA_W  write-back value
- `wb_fault`  out  1  misaligned or illegal memory op, qualified by `wb_valid`

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: `ex_ready`=1, combinational from state only.
- On accept of a non-memory op (both memory flags 0), the WB registers load on the same edge with:
  - `wb_data`=`ex_alu_result`, `wb_rd`=`ex_rd`, `wb_reg_write`=`ex_reg_write`, `wb_fault`=0, `wb_valid`=1.
  - State stays IDLE.
- On accept of a memory op, fault if `ex_alu_result[1:0]`≠0 or both `ex_is_load` and `ex_is_store` are 1.
  - Fault: no memory request is made. WB loads `wb_valid`=1, `wb_fault`=1, `wb_reg_write`=0, `wb_data`=`ex_alu_result`. State stays IDLE.
  - Otherwise: register `dmem_addr`=`ex_alu_result`, `dmem_wdata`=`ex_store_data`, `dmem_we`=`ex_is_store`, and the latched rd/reg_write/is_load. Set `dmem_req`=1 and go to ACCESS.
- ACCESS: `ex_ready`=0. `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` are held stable until the first edge with `dmem_ack`=1. On that edge:
  - `dmem_req`←0, state←IDLE, `wb_valid`←1, `wb_fault`←0.
  - Load: `wb_data`←`dmem_rdata`, `wb_reg_write`←latched reg_write.
  - Store: `wb_data`←address, `wb_reg_write`←0.
- `wb_reg_write` is forced to 0 whenever `wb_rd`=0, in every path.
- `dmem_ack` while `dmem_req`=0 is ignored. `ex_*` inputs are ignored while `ex_ready`=0.
- WB outputs hold their last value. Only `wb_valid` returns to 0 in cycles without a retirement.

## Timing
- All outputs are registered except `ex_ready`.
- Reset values: `wb_valid`=0, `wb_reg_write`=0, `wb_fault`=0, `wb_rd`=0, `wb_data`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, state=IDLE (so `ex_ready`=1).
- Non-memory or faulting op: accepted at edge k, `wb_valid` is high for the cycle after edge k. Throughput is 1 per cycle.
- Memory op accepted at edge k:
  - `dmem_req` rises after edge k.
  - If ack is first sampled at edge k+m (m≥1), `wb_valid` pulses after edge k+m and `ex_ready` rises after edge k+m.
  - The next accept is at edge k+m+1 at the earliest.
- Reset asserted mid-ACCESS clears `dmem_req` and all WB outputs immediately, asynchronously. The pending transaction is abandoned, and a late ack after release is ignored.

## Test plan
- Back-to-back ADD results 0x11, 0x22, 0x33 to rd=3,4,5 on consecutive edges -> three consecutive `wb_valid` pulses with matching data and rd; `ex_ready` stays 1 throughout.
- LOAD addr 0x100, memory acks 3 cycles after req with rdata 0xDEADBEEF -> `dmem_req` high 3 cycles with stable addr; `ex_ready`=0 for those 3 cycles; one `wb_valid` pulse with `wb_data`=0xDEADBEEF and `wb_reg_write`=1.
- STORE addr 0x40 data 0xCAFEF00D, ack on the first cycle -> `dmem_we`=1, `dmem_wdata`=0xCAFEF00D, `dmem_req` high 1 cycle; WB pulse with `wb_reg_write`=0.
- LOAD addr 0x102 -> no `dmem_req`; `wb_valid`=1, `wb_fault`=1, `wb_reg_write`=0 one cycle after accept; the same holds with `ex_is_load`=`ex_is_store`=1 at addr 0x100.
- LOAD to rd=0 acked with 0x5 -> `wb_valid`=1, `wb_data`=0x5, `wb_reg_write`=0.
- `rst_n` pulsed low 2 cycles into an unacked LOAD, then an ack 1 cycle after release -> `dmem_req`=0 immediately; no `wb_valid` pulse; `ex_ready`=1 after release.
